mean_mc: RTL and testbench

Multi-channel running-mean filter. The successor to the fixed 32-tap pipelined mean, generalised to:
- C time-interleaved channels;
- a window length 2^k selectable at runtime;
- a recursive running sum instead of an adder tree;
- round-half-up division, a per-channel window-full flag and synchronous clear.

It sits in the same fixed-point filter chain, between sample sources and downstream filter stages, and uses the same two's-complement Q(width_H.width_W) sample format.

---
 rtl/mean_pkg.sv | 27 ++
 rtl/mean_chan_state.sv | 70 +++++++
 rtl/mean_mc.sv | 136 +++++++++++++
 tb/tb_mean_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mean_pkg.sv
// Shared types and helpers for the multi-channel running-mean filter.
// Holds the default Q(5.20) sample geometry, the running-sum type and the
// round-half-up shift that turns a window sum into a mean.
package mean_pkg;

  localparam int unsigned SAMPLE_H  = 5;
  localparam int unsigned SAMPLE_W  = 20;
  localparam int unsigned SAMPLE_D  = SAMPLE_H + SAMPLE_W;
  localparam int unsigned MAX_LOG_N = 5;
  localparam int unsigned LOG_N_W   = $clog2(MAX_LOG_N + 1);
  localparam int unsigned SUM_W     = SAMPLE_D + MAX_LOG_N;

  typedef logic signed [SAMPLE_D-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]    sum_t;
  typedef logic        [LOG_N_W-1:0]  log_n_t;

  // (s + 2^(k-1)) >>> k, i.e. divide by 2^k rounding halves toward +inf.
  // The sum carries LOG_N_MAX guard bits, so the bias can never overflow it.
  function automatic sample_t round_shift(input sum_t s, input log_n_t k);
    sum_t bias;
    sum_t biased;
    bias   = (k == '0) ? '0 : (sum_t'(1) <<< (k - log_n_t'(1)));
    biased = s + bias;
    return sample_t'(biased >>> k);
  endfunction

endpackage

// File: rtl/mean_chan_state.sv
// Per-channel running-sum state: circular sample buffer, write pointer,
// signed running sum and saturating fill counter.
// Ports:
//   clk, rst      clock, async active-low reset
//   clear_i       synchronous clear of all state
//   we_i          accept x_i into this channel this cycle
//   x_i           incoming signed sample
//   k_i           current window exponent (<= LOG_N_MAX)
//   sum_nxt_c     running sum including x_i (combinational)
//   full_nxt_c    channel holds >= 2^k samples including x_i (combinational)
module mean_chan_state #(
  parameter int unsigned D         = 25,
  parameter int unsigned LOG_N_MAX = 5,
  parameter int unsigned KW        = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear_i,
  input  logic                              we_i,
  input  logic        [D-1:0]               x_i,
  input  logic        [KW-1:0]              k_i,
  output logic signed [D+LOG_N_MAX-1:0]     sum_nxt_c,
  output logic                              full_nxt_c
);

  localparam int unsigned N_MAX = 2 ** LOG_N_MAX;
  localparam int unsigned SW    = D + LOG_N_MAX;
  localparam int unsigned CNTW  = LOG_N_MAX + 1;

  logic        [D-1:0]         ring_q [N_MAX];
  logic        [LOG_N_MAX-1:0] wp_q;
  logic signed [SW-1:0]        sum_q;
  logic        [CNTW-1:0]      cnt_q;

  logic        [CNTW-1:0]      win_c;
  logic        [LOG_N_MAX-1:0] rd_idx_c;
  logic        [CNTW-1:0]      cnt_nxt_c;

  // Sample leaving the window sits 2^k slots behind the write pointer;
  // for k = LOG_N_MAX that is the slot about to be overwritten.
  always_comb begin
    win_c      = CNTW'(1) << k_i;
    rd_idx_c   = LOG_N_MAX'({1'b0, wp_q} - win_c);
    sum_nxt_c  = sum_q + SW'(signed'(x_i)) - SW'(signed'(ring_q[rd_idx_c]));
    cnt_nxt_c  = (cnt_q == CNTW'(N_MAX)) ? cnt_q : cnt_q + CNTW'(1);
    full_nxt_c = (cnt_nxt_c >= win_c);
  end

  // State update at the accept edge; zero-filled buffer gives the
  // zero-padded mean until the window fills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_MAX; i++) ring_q[i] <= '0;
      wp_q  <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < N_MAX; i++) ring_q[i] <= '0;
      wp_q  <= '0;
      sum_q <= '0;
      cnt_q <= '0;
    end else if (we_i) begin
      ring_q[wp_q] <= x_i;
      wp_q         <= wp_q + LOG_N_MAX'(1);
      sum_q        <= sum_nxt_c;
      cnt_q        <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/mean_mc.sv
// Multi-channel running-mean filter over a runtime-selectable 2^k window.
// Two-stage pipeline: stage 1 updates channel state and registers the new
// sum; stage 2 rounds/shifts it into the output registers.
// Ports:
//   clk, rst       clock, async active-low reset
//   clear_i        synchronous clear of all channels; loads window exponent
//   cfg_log_n_i    window exponent k, taken while clear_i=1 (clamped)
//   data_i_en      sample valid; chan_i / data_i channel and signed sample
//   data_o_en      result valid; chan_o / data_o / full_o result fields
//   drop_o         one-cycle pulse for a sample on a nonexistent channel
module mean_mc
  import mean_pkg::*;
#(
  parameter  int unsigned width_H   = SAMPLE_H,
  parameter  int unsigned width_W   = SAMPLE_W,
  parameter  int unsigned CHANNELS  = 4,
  parameter  int unsigned LOG_N_MAX = MAX_LOG_N,
  localparam int unsigned D         = width_H + width_W,
  localparam int unsigned CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned KW        = $clog2(LOG_N_MAX + 1),
  localparam int unsigned SW        = D + LOG_N_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic [KW-1:0] cfg_log_n_i,
  input  logic          data_i_en,
  input  logic [CW-1:0] chan_i,
  input  logic [D-1:0]  data_i,
  output logic          data_o_en,
  output logic [CW-1:0] chan_o,
  output logic [D-1:0]  data_o,
  output logic          full_o,
  output logic          drop_o
);

  logic [KW-1:0]        k_q;
  logic                 in_range_c;
  logic                 acc_c;
  logic [CHANNELS-1:0]  we_c;
  logic signed [SW-1:0] chan_sum_c [CHANNELS];
  logic [CHANNELS-1:0]  chan_full_c;
  logic signed [SW-1:0] sel_sum_c;
  logic                 sel_full_c;

  logic                 s1_valid_q;
  logic [CW-1:0]        s1_chan_q;
  logic signed [SW-1:0] s1_sum_q;
  logic                 s1_full_q;

  // Channel range check only exists when the select field can exceed it.
  if ((2 ** CW) > CHANNELS) begin : g_range
    assign in_range_c = (chan_i < CW'(CHANNELS));
  end else begin : g_no_range
    assign in_range_c = 1'b1;
  end

  assign acc_c = data_i_en && !clear_i && in_range_c;

  // Window exponent, clamped to the buffer depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q <= KW'(LOG_N_MAX);
    end else if (clear_i) begin
      k_q <= (cfg_log_n_i > KW'(LOG_N_MAX)) ? KW'(LOG_N_MAX) : cfg_log_n_i;
    end
  end

  // Channel decode and shared stage-1 mux.
  always_comb begin
    we_c       = '0;
    sel_sum_c  = '0;
    sel_full_c = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_i == CW'(c)) begin
        we_c[c]    = acc_c;
        sel_sum_c  = chan_sum_c[c];
        sel_full_c = chan_full_c[c];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    mean_chan_state #(
      .D         (D),
      .LOG_N_MAX (LOG_N_MAX),
      .KW        (KW)
    ) u_state (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear_i),
      .we_i       (we_c[g]),
      .x_i        (data_i),
      .k_i        (k_q),
      .sum_nxt_c  (chan_sum_c[g]),
      .full_nxt_c (chan_full_c[g])
    );
  end

  // Stage 1: capture the updated sum; clear_i suppresses acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_chan_q  <= '0;
      s1_sum_q   <= '0;
      s1_full_q  <= 1'b0;
      drop_o     <= 1'b0;
    end else begin
      s1_valid_q <= acc_c;
      drop_o     <= data_i_en && !clear_i && !in_range_c;
      if (acc_c) begin
        s1_chan_q <= chan_i;
        s1_sum_q  <= sel_sum_c;
        s1_full_q <= sel_full_c;
      end
    end
  end

  // Stage 2: round/shift into output registers; clear_i kills the stage-1 entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o_en <= 1'b0;
      data_o    <= '0;
      chan_o    <= '0;
      full_o    <= 1'b0;
    end else begin
      data_o_en <= s1_valid_q && !clear_i;
      if (s1_valid_q && !clear_i) begin
        data_o <= D'(round_shift(sum_t'(s1_sum_q), log_n_t'(k_q)));
        chan_o <= s1_chan_q;
        full_o <= s1_full_q;
      end
    end
  end

endmodule

// File: tb/tb_mean_mc.sv
// Self-checking bench for mean_mc: directed scenarios plus randomized traffic
// against a sample-history reference model.
module tb_mean_mc;

  localparam int unsigned CH        = 3;
  localparam int unsigned D         = 25;
  localparam int unsigned CW        = 2;
  localparam int unsigned KW        = 3;
  localparam int unsigned LOG_N_MAX = 5;
  localparam longint      MAXP      = (longint'(1) << 24) - 1;
  localparam longint      MINN      = -(longint'(1) << 24);

  logic                clk = 1'b0;
  logic                rst;
  logic                clear_i;
  logic [KW-1:0]       cfg_log_n_i;
  logic                data_i_en;
  logic [CW-1:0]       chan_i;
  logic signed [D-1:0] data_i;
  logic                data_o_en;
  logic [CW-1:0]       chan_o;
  logic signed [D-1:0] data_o;
  logic                full_o;
  logic                drop_o;

  always #5 clk = ~clk;

  mean_mc #(
    .width_H   (5),
    .width_W   (20),
    .CHANNELS  (CH),
    .LOG_N_MAX (LOG_N_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear_i),
    .cfg_log_n_i (cfg_log_n_i),
    .data_i_en   (data_i_en),
    .chan_i      (chan_i),
    .data_i      (data_i),
    .data_o_en   (data_o_en),
    .chan_o      (chan_o),
    .data_o      (data_o),
    .full_o      (full_o),
    .drop_o      (drop_o)
  );

  typedef struct { int ch; longint val; } smp_t;
  typedef struct { longint due; int ch; longint mean; bit full; } exp_t;

  smp_t   hist[$];
  exp_t   exp_q[$];
  int     k_m;
  longint cycle;
  longint drop_due;
  longint last_data;
  longint last_chan;
  longint last_full;
  int     errors;
  int     checks;
  longint ramp[5] = '{4, 8, 12, 16, 0};

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Mean of the newest 2^k samples of a channel since clear, zero padded.
  function automatic void model_eval(input int ch, output longint mean, output bit full);
    longint n;
    longint s;
    longint seen;
    n    = longint'(1) << k_m;
    s    = 0;
    seen = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].ch == ch) begin
        if (seen < n) s += hist[i].val;
        seen++;
      end
    end
    full = (seen >= n);
    mean = floor_div(s + n / 2, n);
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    k_m       = LOG_N_MAX;
    drop_due  = -1;
    last_data = 0;
    last_chan = 0;
    last_full = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    data_i_en = 1'b0;
    clear_i   = 1'b0;
    #1;
    model_reset();
    check("rst_en",   longint'(data_o_en), 0);
    check("rst_data", longint'(data_o), 0);
    check("rst_chan", longint'(chan_o), 0);
    check("rst_full", longint'(full_o), 0);
    check("rst_drop", longint'(drop_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive inputs, update model at the edge, check outputs after it.
  task automatic step(input bit en, input int ch, input longint val,
                      input bit clr, input int cfg);
    exp_t   e;
    longint m;
    bit     f;
    bit     exp_en;
    @(negedge clk);
    data_i_en   = en;
    chan_i      = CW'(ch);
    data_i      = D'(val);
    clear_i     = clr;
    cfg_log_n_i = KW'(cfg);
    @(posedge clk);
    cycle++;
    if (clr) begin
      hist.delete();
      exp_q.delete();
      k_m = (cfg > int'(LOG_N_MAX)) ? int'(LOG_N_MAX) : cfg;
    end else if (en) begin
      if (ch < int'(CH)) begin
        hist.push_back('{ch: ch, val: val});
        model_eval(ch, m, f);
        exp_q.push_back('{due: cycle + 1, ch: ch, mean: m, full: f});
      end else begin
        drop_due = cycle;
      end
    end
    #1;
    exp_en = (exp_q.size() > 0) && (exp_q[0].due == cycle);
    check("data_o_en", longint'(data_o_en), longint'(exp_en));
    if (exp_en) begin
      e = exp_q.pop_front();
      last_data = e.mean;
      last_chan = e.ch;
      last_full = e.full;
    end
    check("data_o", longint'(data_o), last_data);
    check("chan_o", longint'(chan_o), last_chan);
    check("full_o", longint'(full_o), last_full);
    check("drop_o", longint'(drop_o), longint'(drop_due == cycle));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    longint v;
    logic signed [D-1:0] r;
    int sel;
    rst = 1'b0; clear_i = 1'b0; data_i_en = 1'b0;
    chan_i = '0; data_i = '0; cfg_log_n_i = '0;
    errors = 0; checks = 0; cycle = 0;
    model_reset();
    do_reset();

    // k=2 ramp on ch0
    step(1'b0, 0, 0, 1'b1, 2);
    for (int i = 0; i < 5; i++) step(1'b1, 0, ramp[i], 1'b0, 0);
    idle(2);

    // k=1 negatives and max-positive pair on ch1
    step(1'b0, 0, 0, 1'b1, 1);
    step(1'b1, 1, -3, 1'b0, 0);
    step(1'b1, 1, 0, 1'b0, 0);
    step(1'b1, 1, MAXP, 1'b0, 0);
    step(1'b1, 1, MAXP, 1'b0, 0);
    idle(2);

    // interleaved channels at k=1
    step(1'b0, 0, 0, 1'b1, 1);
    step(1'b1, 0, 100, 1'b0, 0);
    step(1'b1, 1, 200, 1'b0, 0);
    step(1'b1, 0, 300, 1'b0, 0);
    step(1'b1, 1, 400, 1'b0, 0);
    idle(2);

    // clear with samples in flight, oversized exponent clamps to 5
    step(1'b1, 2, 500, 1'b0, 0);
    step(1'b1, 2, 600, 1'b1, 7);
    step(1'b1, 2, 32, 1'b0, 0);
    idle(2);

    // nonexistent channel is dropped, other channels untouched
    step(1'b1, 0, 64, 1'b0, 0);
    step(1'b1, 3, 77, 1'b0, 0);
    step(1'b1, 0, 64, 1'b0, 0);
    step(1'b1, 2, -32, 1'b0, 0);
    idle(2);

    // reset mid-stream, then k=3
    step(1'b1, 0, 5, 1'b0, 0);
    step(1'b1, 1, 6, 1'b0, 0);
    do_reset();
    step(1'b0, 0, 0, 1'b1, 3);
    step(1'b1, 0, 8, 1'b0, 0);
    idle(2);

    // random traffic with extremes, clears and resets
    step(1'b0, 0, 0, 1'b1, 2);
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom_range(0, 9));
      r   = D'($urandom);
      v   = (sel == 0) ? MAXP : (sel == 1) ? MINN : longint'(r);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), v,
             ($urandom_range(0, 59) == 0), int'($urandom_range(0, 7)));
      end
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
